mem_arb: RTL and testbench
==========================

# mem_arb

Parametrised memory arbiter/sequencer between NUM_CH requester channels (instruction cache, load/store, future prefetch) and the single byte-wide external memory bus of the CPU top. It generalises the two-client controller to N channels, adds per-request access size (1/2/4 bytes), round-robin fairness, speculative-read abort on pipeline clear, and UART back-pressure on I/O writes. Sits directly between the requesters and the mem_din/mem_dout/mem_a/mem_wr pins.

## Interface
- NUM_CH, default 2: number of requester channels (1..8).
- FLUSH_MASK, default 2'b01: bit i set means channel i reads are aborted by clr.
- IO_HI, default 2'b11: value of addr[17:16] that selects the I/O space.
- clk  in  1  system clock (clk_in & rdy_in at the top).
- rst  in  1  reset. Asynchronous, active-high.
- rdy  in  1  when low, FSM/counters/pointer freeze and mem_wr forced 0.
- clr  in  1  pipeline clear (misprediction).
- req_rn  in  NUM_CH  per-channel read request, level, held until resp_ready.
- req_wn  in  NUM_CH  per-channel write request, level; rn and wn never both set.
- req_addr  in  32*NUM_CH  byte address, channel i at [32i+31:32i].
- req_wdata  in  32*NUM_CH  write data, little-endian.
- req_size  in  2*NUM_CH  0=byte, 1=half, 2=word; 3 is treated as word.
- resp_ready  out  NUM_CH  one-cycle completion pulse to owning channel.
- resp_data  out  32  read data, zero-extended, valid with resp_ready.
- mem_din  in  8  memory read byte (data for address issued previous cycle).
- mem_dout  out  8  memory write byte.
- mem_a  out  32  memory address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART TX buffer full.

## Operation
- States: IDLE, RD, RD_LAST, WR, DONE.
- IDLE: select one channel with rn|wn; latch addr, wdata, n=size bytes, owner; go RD or WR. No request: stay IDLE, mem_a=0, mem_wr=0.
- RD: cycle k (k=0..n-1) drives mem_a=addr+k, mem_wr=0; byte from cycle k captured next cycle into byte lane k. After issuing byte n-1 go RD_LAST (capture final byte), then DONE.
- WR: cycle k drives mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1; after byte n-1 go DONE.
- I/O stall: WR byte with addr[17:16]==IO_HI while io_buffer_full=1: mem_wr=0, hold k, retry next cycle.
- DONE: resp_ready[owner]=1 for one cycle, resp_data valid; next state IDLE. Requester drops request before the following IDLE cycle.
- clr in any RD/RD_LAST cycle with FLUSH_MASK[owner]=1: abort, next state IDLE, no resp_ready. Writes and unmasked reads always complete. In IDLE with clr=1, masked channels are not eligible that cycle.
- Address increment wraps modulo 2^32; misaligned accesses allowed.
- Read capture register updates from mem_din even when rdy=0 (memory returns data regardless).

## Timing
- Request seen in IDLE at cycle G. Read of n bytes: resp_ready at G+n+2 (word: G+6). Write: resp_ready at G+n+1 (word: G+5), plus stall cycles.
- Back-to-back: one IDLE cycle between transactions.
- Reset values: all resp_ready 0, resp_data 0, mem_a 0, mem_dout 0, mem_wr 0, state IDLE, RR pointer 0.
- Reset mid-transaction: immediate return to reset values; no pulse.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; search starts at channel after last granted owner.
- Undefined: fixed priority, lowest index wins (channel 0 = highest).

## Structure
- Shared package/constants: size encodings, IO_HI, state encoding, Data_Bus width.
- One sub-module: rr_arbiter (NUM_CH, request vector, enable, one-hot grant, pointer update on grant).

## Test plan
- Ch0 word read addr 0x1000, memory bytes 11 22 33 44 -> mem_a 0x1000..0x1003 on G+1..G+4, resp_ready[0] at G+6, resp_data 0x44332211.
- Ch1 half write 0x0000BEEF to 0x2002 -> mem_wr=1 with EF@0x2002, BE@0x2003, resp_ready[1] at G+3.
- Ch0 and ch1 requesting continuously, MEM_ARB_RR_EN defined -> grants alternate 0,1,0,1; undefined -> ch0 always wins while held.
- Byte write 0x41 to 0x30000, io_buffer_full high 3 cycles -> mem_wr low 3 cycles, then one write, resp_ready one cycle later.
- Ch0 word read, clr at 2nd RD cycle with FLUSH_MASK=01 -> IDLE next cycle, no resp_ready[0]; same with ch1 write -> completes normally.
- rst asserted mid word write -> mem_wr 0 same cycle, no resp_ready, next request served from IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and types for the memory arbiter slice.
//   - Bus widths (address, word, external data bus)
//   - Access-size encodings and the helper that maps a size to its last byte index
//   - FSM state encoding
//   - Default I/O space selector (addr[17:16])
package mem_arb_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int DATA_BUS_W = 8;

  localparam logic [1:0] IO_HI_DEF = 2'b11;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_LAST = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Index of the final byte of an access; encoding 3 behaves as a word.
  function automatic logic [1:0] size_last(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_last = 2'd0;
      SZ_HALF: size_last = 2'd1;
      default: size_last = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester-side bundle of the memory arbiter.
//   req_rn/req_wn   per-channel read/write request levels
//   req_addr        32-bit byte address per channel, channel i at [32i+31:32i]
//   req_wdata       32-bit little-endian write data per channel
//   req_size        2-bit access size per channel (0 byte, 1 half, 2/3 word)
//   resp_ready      one-cycle completion pulse to the owning channel
//   resp_data       zero-extended read data, valid with resp_ready
// Modports: master = requesters, slave = arbiter.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2
) ();

  logic [NUM_CH-1:0]        req_rn;
  logic [NUM_CH-1:0]        req_wn;
  logic [ADDR_W*NUM_CH-1:0] req_addr;
  logic [WORD_W*NUM_CH-1:0] req_wdata;
  logic [2*NUM_CH-1:0]      req_size;
  logic [NUM_CH-1:0]        resp_ready;
  logic [WORD_W-1:0]        resp_data;

  modport master (
    output req_rn, req_wn, req_addr, req_wdata, req_size,
    input  resp_ready, resp_data
  );

  modport slave (
    input  req_rn, req_wn, req_addr, req_wdata, req_size,
    output resp_ready, resp_data
  );

endinterface

// File: rtl/mem_arb_rr_arbiter.sv
// rr_arbiter: channel selector for mem_arb.
//   clk, rst  clock and asynchronous active-high reset
//   req       eligible-request vector
//   en        arbitration enable (grant only produced when high)
//   gnt       one-hot grant, combinational
//   owner     index of the most recently granted channel (registered)
// Build option MEM_ARB_RR_EN: when defined, round-robin with the search
// starting after the last granted channel; otherwise fixed priority with
// channel 0 highest.
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  localparam int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [PW-1:0]     owner
);

  logic          found;
  logic [PW-1:0] gnt_idx;

`ifdef MEM_ARB_RR_EN
  logic [PW-1:0]     ptr_q;
  logic [NUM_CH-1:0] req_rot;
  logic [NUM_CH-1:0] gnt_rot;

  // Rotate so that bit 0 is the channel at ptr_q, pick the lowest set bit,
  // then rotate the one-hot result back into channel order.
  always_comb begin
    req_rot = NUM_CH'({req, req} >> ptr_q);
    gnt_rot = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en && req_rot[i] && !found) begin
        gnt_rot[i] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt = NUM_CH'(({gnt_rot, gnt_rot} << ptr_q) >> NUM_CH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (|gnt) begin
      ptr_q <= (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en && req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= '0;
    end else if (|gnt) begin
      owner <= gnt_idx;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: N-channel arbiter/sequencer onto the byte-wide external memory bus.
//   clk, rst        clock, asynchronous active-high reset
//   rdy             low freezes FSM, counters and arbitration pointer; mem_wr forced 0
//   clr             pipeline clear; aborts reads of channels set in FLUSH_MASK
//   bus (slave)     requester bundle (see mem_arb_if)
//   mem_din         read byte for the address issued the previous cycle
//   mem_dout/mem_a/mem_wr  memory write byte, address and write strobe
//   io_buffer_full  UART TX full; stalls writes into the I/O space (addr[17:16]==IO_HI)
// Build option MEM_ARB_RR_EN selects round-robin arbitration (see rr_arbiter).
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int              NUM_CH     = 2,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = NUM_CH'(2'b01),
  parameter logic [1:0]      IO_HI      = IO_HI_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clr,
  mem_arb_if.slave              bus,
  input  logic [DATA_BUS_W-1:0] mem_din,
  output logic [DATA_BUS_W-1:0] mem_dout,
  output logic [ADDR_W-1:0]     mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              state_q, state_nx;
  logic [1:0]          k_q, k_nx;
  logic [1:0]          last_q;
  logic [ADDR_W-1:0]   addr_q, byte_addr, sel_addr;
  logic [WORD_W-1:0]   wdata_q, sel_wdata, rdata_q;
  logic [1:0]          sel_size;
  logic                sel_rd;
  logic [NUM_CH-1:0]   elig, gnt;
  logic [PW-1:0]       owner;
  logic                arb_en, grant, own_flush, abort, io_stall;
  logic                iss_vld_p1;
  logic [1:0]          iss_lane_p1;

  // Eligibility, granted-channel field select and owner flush flag.
  always_comb begin
    elig      = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_size  = '0;
    sel_rd    = 1'b0;
    own_flush = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = (bus.req_rn[i] | bus.req_wn[i]) & ~(clr & FLUSH_MASK[i]);
      if (gnt[i]) begin
        sel_addr  = bus.req_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = bus.req_wdata[WORD_W*i +: WORD_W];
        sel_size  = bus.req_size[2*i +: 2];
        sel_rd    = bus.req_rn[i];
      end
      if (owner == PW'(i)) own_flush = FLUSH_MASK[i];
    end
  end

  assign arb_en    = (state_q == ST_IDLE) && rdy;
  assign grant     = |gnt;
  assign byte_addr = addr_q + ADDR_W'(k_q);
  assign abort     = clr && own_flush;
  assign io_stall  = io_buffer_full && (byte_addr[17:16] == IO_HI);

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (elig),
    .en    (arb_en),
    .gnt   (gnt),
    .owner (owner)
  );

  always_comb begin
    state_nx       = state_q;
    k_nx           = k_q;
    mem_a          = '0;
    mem_dout       = '0;
    mem_wr         = 1'b0;
    bus.resp_ready = '0;
    bus.resp_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_nx = sel_rd ? ST_RD : ST_WR;
          k_nx     = '0;
        end
      end
      ST_RD: begin
        mem_a = byte_addr;
        if (rdy) begin
          if (abort)               state_nx = ST_IDLE;
          else if (k_q == last_q)  state_nx = ST_RD_LAST;
          else                     k_nx     = k_q + 2'd1;
        end
      end
      ST_RD_LAST: begin
        if (rdy) state_nx = abort ? ST_IDLE : ST_DONE;
      end
      ST_WR: begin
        mem_a    = byte_addr;
        mem_dout = wdata_q[{k_q, 3'b000} +: DATA_BUS_W];
        // A stalled I/O byte keeps k so the same byte is retried.
        if (rdy && !io_stall) begin
          mem_wr = 1'b1;
          if (k_q == last_q) state_nx = ST_DONE;
          else               k_nx     = k_q + 2'd1;
        end
      end
      ST_DONE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          bus.resp_ready[i] = rdy && (owner == PW'(i));
        end
        bus.resp_data = rdata_q;
        if (rdy) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      iss_vld_p1  <= 1'b0;
      iss_lane_p1 <= '0;
    end else begin
      state_q     <= state_nx;
      k_q         <= k_nx;
      // Issue -> capture boundary: memory answers regardless of rdy.
      iss_vld_p1  <= (state_q == ST_RD);
      iss_lane_p1 <= k_q;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      last_q  <= size_last(sel_size);
    end
  end

  // Capture stage: byte issued last cycle lands in its lane.
  always_ff @(posedge clk) begin
    if (grant) begin
      rdata_q <= '0;
    end else if (iss_vld_p1) begin
      rdata_q[{iss_lane_p1, 3'b000} +: DATA_BUS_W] <= mem_din;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb (two channels, default parameters).
// Expectations for the arbitration sequence follow MEM_ARB_RR_EN.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arb_if #(.NUM_CH(2)) bus ();

  mem_arb #(.NUM_CH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clr            (clr),
    .bus            (bus),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h1000: mem_byte = 8'h11;
      32'h1001: mem_byte = 8'h22;
      32'h1002: mem_byte = 8'h33;
      32'h1003: mem_byte = 8'h44;
      default:  mem_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Memory returns the byte for the address presented in the previous cycle.
  always @(posedge clk) mem_din <= mem_byte(mem_a);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input logic ch, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    bus.req_rn[ch] = rd;
    bus.req_wn[ch] = wr;
    if (ch) begin
      bus.req_addr[63:32]  = a;
      bus.req_wdata[63:32] = wd;
      bus.req_size[3:2]    = sz;
    end else begin
      bus.req_addr[31:0]   = a;
      bus.req_wdata[31:0]  = wd;
      bus.req_size[1:0]    = sz;
    end
  endtask

  task automatic drop_ch(input logic ch);
    bus.req_rn[ch] = 1'b0;
    bus.req_wn[ch] = 1'b0;
  endtask

  logic [31:0] exp_gnt;
  logic [31:0] exp_dat;

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
    bus.req_rn = '0; bus.req_wn = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_size = '0;

    // Reset state
    step(); step(); #1;
    chk("rst_resp_ready", 32'(bus.resp_ready), 32'h0);
    chk("rst_resp_data",  bus.resp_data,       32'h0);
    chk("rst_mem_a",      mem_a,               32'h0);
    chk("rst_mem_dout",   32'(mem_dout),       32'h0);
    chk("rst_mem_wr",     32'(mem_wr),         32'h0);
    rst = 1'b0;

    // Channel 0 word read at 0x1000
    step();
    set_ch(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 2'd2);
    #1; chk("t1_idle_mem_a", mem_a, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      chk("t1_rd_addr", mem_a, 32'h1000 + 32'(k));
      chk("t1_rd_wr",   32'(mem_wr), 32'h0);
    end
    step(); #1; chk("t1_rdlast_resp", 32'(bus.resp_ready), 32'h0);
    step(); #1;
    chk("t1_done_resp", 32'(bus.resp_ready), 32'h1);
    chk("t1_done_data", bus.resp_data, 32'h44332211);
    drop_ch(1'b0);
    step(); #1;
    chk("t1_idle_resp", 32'(bus.resp_ready), 32'h0);
    chk("t1_idle_data", bus.resp_data, 32'h0);

    // Channel 1 half write 0xBEEF at 0x2002
    set_ch(1'b1, 1'b0, 1'b1, 32'h2002, 32'h0000BEEF, 2'd1);
    step(); #1;
    chk("t2_b0_wr",   32'(mem_wr), 32'h1);
    chk("t2_b0_addr", mem_a, 32'h2002);
    chk("t2_b0_dout", 32'(mem_dout), 32'hEF);
    step(); #1;
    chk("t2_b1_wr",   32'(mem_wr), 32'h1);
    chk("t2_b1_addr", mem_a, 32'h2003);
    chk("t2_b1_dout", 32'(mem_dout), 32'hBE);
    step(); #1;
    chk("t2_done_resp", 32'(bus.resp_ready), 32'h2);
    drop_ch(1'b1);
    step(); #1;
    chk("t2_idle_wr",   32'(mem_wr), 32'h0);
    chk("t2_idle_resp", 32'(bus.resp_ready), 32'h0);

    // Both channels requesting byte reads continuously
    set_ch(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 2'd0);
    set_ch(1'b1, 1'b1, 1'b0, 32'h1001, 32'h0, 2'd0);
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
      exp_gnt = (t % 2 == 0) ? 32'h1 : 32'h2;
`else
      exp_gnt = 32'h1;
`endif
      exp_dat = (exp_gnt == 32'h1) ? 32'h11 : 32'h22;
      repeat (3) step();
      #1;
      chk("t3_grant", 32'(bus.resp_ready), exp_gnt);
      chk("t3_data",  bus.resp_data, exp_dat);
      step();
    end
    drop_ch(1'b0);
    drop_ch(1'b1);

    // I/O byte write with UART buffer full for three cycles
    set_ch(1'b0, 1'b0, 1'b1, 32'h00030000, 32'h41, 2'd0);
    io_buffer_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step(); #1;
      chk("t4_stall_wr", 32'(mem_wr), 32'h0);
    end
    step();
    io_buffer_full = 1'b0;
    #1;
    chk("t4_wr",      32'(mem_wr), 32'h1);
    chk("t4_wr_addr", mem_a, 32'h00030000);
    chk("t4_wr_dout", 32'(mem_dout), 32'h41);
    step(); #1;
    chk("t4_done_resp", 32'(bus.resp_ready), 32'h1);
    drop_ch(1'b0);
    step(); #1;
    chk("t4_idle_wr",   32'(mem_wr), 32'h0);
    chk("t4_idle_resp", 32'(bus.resp_ready), 32'h0);

    // Clear during a masked read aborts it
    set_ch(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 2'd2);
    step();
    step();
    clr = 1'b1;
    #1; chk("t5_rd1_addr", mem_a, 32'h1001);
    step();
    clr = 1'b0;
    drop_ch(1'b0);
    #1;
    chk("t5_abort_addr", mem_a, 32'h0);
    chk("t5_abort_resp", 32'(bus.resp_ready), 32'h0);
    for (int s = 0; s < 4; s++) begin
      step(); #1;
      chk("t5_no_resp", 32'(bus.resp_ready), 32'h0);
    end

    // Clear during a write is ignored
    set_ch(1'b1, 1'b0, 1'b1, 32'h2000, 32'h11223344, 2'd2);
    step();
    step();
    clr = 1'b1;
    #1;
    chk("t5w_b1_addr", mem_a, 32'h2001);
    chk("t5w_b1_wr",   32'(mem_wr), 32'h1);
    step();
    clr = 1'b0;
    #1;
    chk("t5w_b2_addr", mem_a, 32'h2002);
    chk("t5w_b2_dout", 32'(mem_dout), 32'h22);
    step(); #1;
    chk("t5w_b3_addr", mem_a, 32'h2003);
    chk("t5w_b3_dout", 32'(mem_dout), 32'h11);
    step(); #1;
    chk("t5w_done_resp", 32'(bus.resp_ready), 32'h2);
    drop_ch(1'b1);
    step();

    // Reset in the middle of a word write
    set_ch(1'b0, 1'b0, 1'b1, 32'h3000, 32'hA5A5A5A5, 2'd2);
    step();
    step(); #1;
    chk("t6_pre_wr",   32'(mem_wr), 32'h1);
    chk("t6_pre_addr", mem_a, 32'h3001);
    rst = 1'b1;
    drop_ch(1'b0);
    #1;
    chk("t6_rst_wr",   32'(mem_wr), 32'h0);
    chk("t6_rst_addr", mem_a, 32'h0);
    chk("t6_rst_dout", 32'(mem_dout), 32'h0);
    step(); #1;
    chk("t6_rst_resp", 32'(bus.resp_ready), 32'h0);
    rst = 1'b0;
    set_ch(1'b1, 1'b1, 1'b0, 32'h1002, 32'h0, 2'd0);
    step(); #1;
    chk("t6_rd_addr", mem_a, 32'h1002);
    step();
    step(); #1;
    chk("t6_done_resp", 32'(bus.resp_ready), 32'h2);
    chk("t6_done_data", bus.resp_data, 32'h33);
    drop_ch(1'b1);
    step(); #1;
    chk("t6_idle_resp", 32'(bus.resp_ready), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
